// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command front end.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    CHK,
    ISSUE
  } parser_state_e;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'd0,
    ERR_BAD_CMD = 2'd1,
    ERR_CHKSUM  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam logic [7:0] CMD_WRITE         = 8'h57;
  localparam logic [7:0] CMD_READ          = 8'h52;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte gap timer: o_tc pulses on the TIMEOUT_CYCLES-th consecutive enabled, uncleared cycle.
// Combinational o_tc from a registered count; i_clr always wins over the terminal count.
module uart_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  // r_cnt already holds the number of silent cycles before this one
  assign o_tc = i_en && !i_clr && (r_cnt == TC_VAL);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/opcode/addr/data/XOR-checksum frames from uart_rx into one register request.
// req_valid rises the cycle after the CHK byte and holds until req_ready; errors are 1-cycle pulses.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         ADDR_BYTES     = 2,
  parameter int         DATA_BYTES     = 4,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_we,
  output logic [8*ADDR_BYTES-1:0] req_addr,
  output logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    err_valid,
  output logic [1:0]              err_code
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BCW  = $clog2(MAXB + 1);
  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);

  parser_state_e   r_state;
  logic [BCW-1:0]  r_cnt;
  logic [7:0]      r_chk;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_req_valid;
  logic            r_err_valid;
  err_code_e       r_err_code;

  logic w_active;
  logic w_tmr_clr;
  logic w_tc;

  assign w_active  = (r_state == CMD) || (r_state == ADDR) ||
                     (r_state == DATA) || (r_state == CHK);
  assign w_tmr_clr = rx_valid || !w_active;

  uart_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_tmr_clr),
    .i_en  (w_active),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_chk       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_OVERRUN;
    end else begin
      r_err_valid <= 1'b0;
      if (w_tc) begin
        r_err_valid <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) r_state <= CMD;
          end
          CMD: begin
            if (rx_valid) begin
              if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                r_we    <= (rx_data == CMD_WRITE);
                r_chk   <= rx_data;
                r_cnt   <= '0;
                r_wdata <= '0;
                r_state <= ADDR;
              end else begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_BAD_CMD;
                r_state     <= IDLE;
              end
            end
          end
          ADDR: begin
            if (rx_valid) begin
              r_addr <= AW'({r_addr, rx_data});
              r_chk  <= r_chk ^ rx_data;
              if (r_cnt == ADDR_LAST) begin
                r_cnt   <= '0;
                r_state <= r_we ? DATA : CHK;
              end else begin
                r_cnt <= r_cnt + BCW'(1);
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              r_wdata <= DW'({r_wdata, rx_data});
              r_chk   <= r_chk ^ rx_data;
              if (r_cnt == DATA_LAST) begin
                r_cnt   <= '0;
                r_state <= CHK;
              end else begin
                r_cnt <= r_cnt + BCW'(1);
              end
            end
          end
          CHK: begin
            if (rx_valid) begin
              if (rx_data == r_chk) begin
                r_req_valid <= 1'b1;
                r_state     <= ISSUE;
              end else begin
                r_err_valid <= 1'b1;
                r_err_code  <= ERR_CHKSUM;
                r_state     <= IDLE;
              end
            end
          end
          ISSUE: begin
            // Bytes arriving while the request is pending are lost; the request itself is untouched
            if (rx_valid) begin
              r_err_valid <= 1'b1;
              r_err_code  <= ERR_OVERRUN;
            end
            if (r_req_valid && req_ready) begin
              r_req_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign req_valid = r_req_valid;
  assign req_we    = r_we;
  assign req_addr  = r_addr;
  assign req_wdata = r_wdata;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames, errors, timeout boundary, backpressure and reset.
module tb_uart_cmd_parser;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        err_valid;
  logic [1:0]  err_code;

  int n_checks;
  int n_errors;
  int err_pulses;
  int hs_cnt;
  int err_mark;
  int hs_mark;
  byte_q_t q;

  uart_cmd_parser #(
    .ADDR_BYTES    (2),
    .DATA_BYTES    (4),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .err_valid(err_valid),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pre-edge values are seen here, so each pulse/handshake cycle is counted once
  always @(posedge clk) begin
    if (err_valid) err_pulses <= err_pulses + 1;
    if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    err_pulses = 0;
    hs_cnt     = 0;
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    req_ready  = 1'b1;
    step(2);

    // Reset state
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_we",    32'(req_we),    32'd0);
    check("rst_req_addr",  32'(req_addr),  32'd0);
    check("rst_req_wdata", req_wdata,      32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code",  32'(err_code),  32'd0);
    rst_n = 1'b1;
    step(1);

    // Write frame, zero-wait ready
    err_mark = err_pulses;
    hs_mark  = hs_cnt;
    q = '{8'hA5, 8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_seq(q);
    check("wr_no_early_req", 32'(req_valid), 32'd0);
    send_byte(8'h65);
    check("wr_req_valid", 32'(req_valid), 32'd1);
    check("wr_req_we",    32'(req_we),    32'd1);
    check("wr_req_addr",  32'(req_addr),  32'h0010);
    check("wr_req_wdata", req_wdata,      32'hDEADBEEF);
    step(1);
    check("wr_req_one_cycle", 32'(req_valid), 32'd0);
    check("wr_handshakes", 32'(hs_cnt - hs_mark), 32'd1);
    check("wr_no_err", 32'(err_pulses - err_mark), 32'd0);

    // Read frame preceded by garbage
    err_mark = err_pulses;
    q = '{8'h00, 8'hFF, 8'hA5, 8'h52, 8'h12, 8'h34, 8'h74};
    send_seq(q);
    check("rd_req_valid", 32'(req_valid), 32'd1);
    check("rd_req_we",    32'(req_we),    32'd0);
    check("rd_req_addr",  32'(req_addr),  32'h1234);
    check("rd_req_wdata", req_wdata,      32'd0);
    step(1);
    check("rd_no_err", 32'(err_pulses - err_mark), 32'd0);

    // Bad checksum, then a good read
    q = '{8'hA5, 8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
    send_seq(q);
    check("chk_err_valid", 32'(err_valid), 32'd1);
    check("chk_err_code",  32'(err_code),  32'd2);
    check("chk_no_req",    32'(req_valid), 32'd0);
    step(1);
    check("chk_err_one_cycle", 32'(err_valid), 32'd0);
    q = '{8'hA5, 8'h52, 8'h12, 8'h34, 8'h74};
    send_seq(q);
    check("chk_next_req_valid", 32'(req_valid), 32'd1);
    check("chk_next_req_addr",  32'(req_addr),  32'h1234);
    step(1);

    // Bad opcode, then a good read
    q = '{8'hA5, 8'h41};
    send_seq(q);
    check("cmd_err_valid", 32'(err_valid), 32'd1);
    check("cmd_err_code",  32'(err_code),  32'd1);
    q = '{8'hA5, 8'h52, 8'h00, 8'h01, 8'h53};
    send_seq(q);
    check("cmd_next_req_valid", 32'(req_valid), 32'd1);
    check("cmd_next_req_we",    32'(req_we),    32'd0);
    check("cmd_next_req_addr",  32'(req_addr),  32'h0001);
    step(1);

    // Timeout after 100 silent cycles mid-frame
    q = '{8'hA5, 8'h57, 8'h00};
    send_seq(q);
    step(99);
    check("to_not_early", 32'(err_valid), 32'd0);
    step(1);
    check("to_err_valid", 32'(err_valid), 32'd1);
    check("to_err_code",  32'(err_code),  32'd3);
    step(1);
    check("to_err_one_cycle", 32'(err_valid), 32'd0);
    q = '{8'hA5, 8'h52, 8'h12, 8'h34, 8'h74};
    send_seq(q);
    check("to_back_idle_req", 32'(req_valid), 32'd1);
    step(1);

    // Byte landing on the terminal-count cycle wins
    err_mark = err_pulses;
    q = '{8'hA5, 8'h57, 8'h00};
    send_seq(q);
    step(99);
    send_byte(8'h10);
    check("to_edge_no_err", 32'(err_valid), 32'd0);
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h65};
    send_seq(q);
    check("to_edge_req_valid", 32'(req_valid), 32'd1);
    check("to_edge_req_addr",  32'(req_addr),  32'h0010);
    check("to_edge_req_wdata", req_wdata,      32'hDEADBEEF);
    step(1);
    check("to_edge_no_err_total", 32'(err_pulses - err_mark), 32'd0);

    // Backpressure with overrun
    req_ready = 1'b0;
    hs_mark   = hs_cnt;
    q = '{8'hA5, 8'h52, 8'h12, 8'h34, 8'h74};
    send_seq(q);
    check("bp_req_valid", 32'(req_valid), 32'd1);
    step(4);
    send_byte(8'h3C);
    check("bp_ovr_err_valid", 32'(err_valid), 32'd1);
    check("bp_ovr_err_code",  32'(err_code),  32'd0);
    step(14);
    check("bp_hold_valid", 32'(req_valid), 32'd1);
    check("bp_hold_we",    32'(req_we),    32'd0);
    check("bp_hold_addr",  32'(req_addr),  32'h1234);
    check("bp_hold_wdata", req_wdata,      32'd0);
    check("bp_no_hs_yet",  32'(hs_cnt - hs_mark), 32'd0);
    req_ready = 1'b1;
    send_byte(8'h3C);
    check("bp_hs_drop_valid",  32'(req_valid), 32'd0);
    check("bp_hs_ovr_valid",   32'(err_valid), 32'd1);
    check("bp_hs_ovr_code",    32'(err_code),  32'd0);
    step(2);
    check("bp_single_hs", 32'(hs_cnt - hs_mark), 32'd1);

    // Asynchronous reset while a request is pending
    req_ready = 1'b0;
    q = '{8'hA5, 8'h52, 8'h12, 8'h34, 8'h74};
    send_seq(q);
    check("rst_pre_req_valid", 32'(req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", 32'(req_valid), 32'd0);
    check("arst_req_addr",  32'(req_addr),  32'd0);
    step(1);
    rst_n     = 1'b1;
    req_ready = 1'b1;
    step(1);

    // Reset mid-frame discards the partial frame
    q = '{8'hA5, 8'h57, 8'h00, 8'h10};
    send_seq(q);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_err_valid", 32'(err_valid), 32'd0);
    check("mid_rst_req_we",    32'(req_we),    32'd0);
    rst_n    = 1'b1;
    err_mark = err_pulses;
    step(1);
    q = '{8'hA5, 8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h65};
    send_seq(q);
    check("post_rst_req_valid", 32'(req_valid), 32'd1);
    check("post_rst_req_we",    32'(req_we),    32'd1);
    check("post_rst_req_addr",  32'(req_addr),  32'h0010);
    check("post_rst_req_wdata", req_wdata,      32'hDEADBEEF);
    step(1);
    check("post_rst_no_err", 32'(err_pulses - err_mark), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
